// File: rtl/unsigned_calc_pkg.sv
// Shared definitions for the unsigned calculator datapath and its solver.
//   W_IN / W_OUT     : operand width and result/target width
//   CAND_MAX         : largest value an operand takes during the sweep
//   COEF_A/B/C       : coefficients of F = 7X - 3Y + 6Z
//   state_t          : solver FSM states
package unsigned_calc_pkg;

    localparam int W_IN  = 4;
    localparam int W_OUT = 8;

    localparam logic [3:0] CAND_MAX = 4'd15;

    localparam int COEF_A = 7;
    localparam int COEF_B = 3;
    localparam int COEF_C = 6;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

endpackage

// File: rtl/unsigned_calc_v.sv
// Combinational evaluator: o_fu = 7*X - 3*Y + 6*Z, wrapped to W_OUT bits
// (two's complement).
//   i_au : X, unsigned W_IN bits
//   i_bu : Y, unsigned W_IN bits
//   i_cu : Z, unsigned W_IN bits
//   o_fu : result, W_OUT bits, signed interpretation
module unsigned_calc_v
    import unsigned_calc_pkg::*;
#(
    parameter int W_IN  = unsigned_calc_pkg::W_IN,
    parameter int W_OUT = unsigned_calc_pkg::W_OUT
) (
    input  logic [W_IN-1:0]  i_au,
    input  logic [W_IN-1:0]  i_bu,
    input  logic [W_IN-1:0]  i_cu,
    output logic [W_OUT-1:0] o_fu
);

    localparam logic signed [W_OUT-1:0] KA = W_OUT'(COEF_A);
    localparam logic signed [W_OUT-1:0] KB = W_OUT'(COEF_B);
    localparam logic signed [W_OUT-1:0] KC = W_OUT'(COEF_C);

    logic signed [W_OUT-1:0] a_s;
    logic signed [W_OUT-1:0] b_s;
    logic signed [W_OUT-1:0] c_s;
    logic signed [W_OUT-1:0] f_s;

    // Operands are zero-extended so they stay non-negative in signed math;
    // the W_OUT-bit product/sum wraps exactly like the hardware result.
    assign a_s = signed'({{(W_OUT-W_IN){1'b0}}, i_au});
    assign b_s = signed'({{(W_OUT-W_IN){1'b0}}, i_bu});
    assign c_s = signed'({{(W_OUT-W_IN){1'b0}}, i_cu});

    assign f_s  = (a_s * KA) - (b_s * KB) + (c_s * KC);
    assign o_fu = f_s;

endmodule

// File: rtl/unsigned_calc_solver_v.sv
// Sequential inverse of unsigned_calc_v. Given a target F it sweeps every
// (X, Y, Z) candidate, one per clock, and reports the first one whose
// wrapped 8-bit result equals F.
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset
//   i_start : search request, accepted only in IDLE
//   i_fu    : target F, latched on an accepted start
//   o_busy  : high while searching
//   o_done  : one-cycle pulse when a search finishes
//   o_found : 1 = match found, 0 = no solution (valid from o_done on)
//   o_au    : X of the first match (0 if none)
//   o_bu    : Y of the first match (0 if none)
//   o_cu    : Z of the first match (0 if none)
module unsigned_calc_solver_v
    import unsigned_calc_pkg::*;
#(
    parameter int W_IN  = unsigned_calc_pkg::W_IN,
    parameter int W_OUT = unsigned_calc_pkg::W_OUT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [W_OUT-1:0] i_fu,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_found,
    output logic [W_IN-1:0]  o_au,
    output logic [W_IN-1:0]  o_bu,
    output logic [W_IN-1:0]  o_cu
);

    localparam int CNT_W = 3 * W_IN;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [W_OUT-1:0]   target_q;

    logic [W_IN-1:0]    x_q;
    logic [W_IN-1:0]    y_q;
    logic [W_IN-1:0]    z_q;
    logic [W_OUT-1:0]   calc_fu;
    logic               match;
    logic               last_cand;

    // One flat counter gives the Z-fastest, then Y, then X order for free:
    // index k = {X, Y, Z}, and the carries fall out of the increment.
    assign x_q = cnt_q[CNT_W-1      -: W_IN];
    assign y_q = cnt_q[2*W_IN-1     -: W_IN];
    assign z_q = cnt_q[W_IN-1       -: W_IN];

    unsigned_calc_v #(
        .W_IN  (W_IN),
        .W_OUT (W_OUT)
    ) u_calc (
        .i_au (x_q),
        .i_bu (y_q),
        .i_cu (z_q),
        .o_fu (calc_fu)
    );

    assign match     = (calc_fu == target_q);
    assign last_cand = &cnt_q;
    assign o_busy    = (state_q == SEARCH);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            target_q <= '0;
            o_done   <= 1'b0;
            o_found  <= 1'b0;
            o_au     <= '0;
            o_bu     <= '0;
            o_cu     <= '0;
        end else begin
            o_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        target_q <= i_fu;
                        cnt_q    <= '0;
                        o_found  <= 1'b0;
                        o_au     <= '0;
                        o_bu     <= '0;
                        o_cu     <= '0;
                        state_q  <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (match) begin
                        o_au    <= x_q;
                        o_bu    <= y_q;
                        o_cu    <= z_q;
                        o_found <= 1'b1;
                        o_done  <= 1'b1;
                        state_q <= IDLE;
                    end else if (last_cand) begin
                        // Whole space exhausted: target is unreachable.
                        o_au    <= '0;
                        o_bu    <= '0;
                        o_cu    <= '0;
                        o_found <= 1'b0;
                        o_done  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unsigned_calc_solver_v.sv
module tb_unsigned_calc_solver_v;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_start;
    logic [7:0] i_fu;
    logic       o_busy;
    logic       o_done;
    logic       o_found;
    logic [3:0] o_au;
    logic [3:0] o_bu;
    logic [3:0] o_cu;

    always #5 i_clk = ~i_clk;

    unsigned_calc_solver_v dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_fu    (i_fu),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_found (o_found),
        .o_au    (o_au),
        .o_bu    (o_bu),
        .o_cu    (o_cu)
    );

    typedef struct {
        logic       found;
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] z;
        int         k;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference: brute-force the equation directly, Z fastest.
    function automatic exp_t model(input logic [7:0] fu);
        exp_t e;
        int   x, y, z, v;
        logic [7:0] v8;
        e.found = 1'b0; e.x = 4'd0; e.y = 4'd0; e.z = 4'd0; e.k = 4095;
        for (int k = 0; k < 4096; k++) begin
            x  = k / 256;
            y  = (k / 16) % 16;
            z  = k % 16;
            v  = 7 * x - 3 * y + 6 * z;
            v8 = v[7:0];
            if (v8 == fu) begin
                e.found = 1'b1;
                e.x = x[3:0]; e.y = y[3:0]; e.z = z[3:0];
                e.k = k;
                return e;
            end
        end
        return e;
    endfunction

    // Pushes the expectation and issues a one-edge start; returns at edge E + 1ns.
    task automatic launch(input logic [7:0] fu);
        sb.push_back(model(fu));
        @(negedge i_clk);
        i_start = 1'b1;
        i_fu    = fu;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_fu    = 8'h5A;
    endtask

    // Counts edges until o_done is seen (sampled 1ns after each edge).
    task automatic wait_done(output int n, output bit timed_out);
        n = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(posedge i_clk);
            #1;
            n++;
            if (o_done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_start = 1'b1;
        i_fu    = 8'h12;
        repeat (2) @(posedge i_clk);
        #1;
        n_checks++;
        if ({o_busy, o_done, o_found, o_au, o_bu, o_cu} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b found=%b x=%0d y=%0d z=%0d, want all 0",
                     o_busy, o_done, o_found, o_au, o_bu, o_cu);
        end
        i_start = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        n_checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", o_busy, o_done);
        end
    endtask

    task automatic test_basic();
        logic [7:0] targets [3] = '{8'h00, 8'hFD, 8'h07};
        exp_t e;
        int   n;
        bit   to;
        for (int t = 0; t < 3; t++) begin
            launch(targets[t]);
            n_checks++;
            if (o_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_busy[%h]: got %b, want 1", targets[t], o_busy);
            end
            wait_done(n, to);
            e = sb.pop_front();
            n_checks++;
            if (to || n != e.k + 1) begin
                n_fail++;
                $display("FAIL basic_latency[%h]: got %0d edges (timeout=%0d), want %0d",
                         targets[t], n, to, e.k + 1);
            end
            n_checks++;
            if ({o_found, o_au, o_bu, o_cu} !== {e.found, e.x, e.y, e.z}) begin
                n_fail++;
                $display("FAIL basic_result[%h]: got found=%b (%0d,%0d,%0d), want found=%b (%0d,%0d,%0d)",
                         targets[t], o_found, o_au, o_bu, o_cu, e.found, e.x, e.y, e.z);
            end
            @(posedge i_clk);
            #1;
            n_checks++;
            if (o_done !== 1'b0 || o_found !== e.found || o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_hold[%h]: got done=%b found=%b busy=%b, want 0 %b 0",
                         targets[t], o_done, o_found, o_busy, e.found);
            end
        end
    endtask

    task automatic test_wrap_ignore_start();
        exp_t e;
        int   n;
        bit   to;
        launch(8'h96);
        repeat (50) @(posedge i_clk);
        #1;
        i_start = 1'b1;
        i_fu    = 8'h00;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        wait_done(n, to);
        e = sb.pop_front();
        n_checks++;
        if (to || 51 + n != e.k + 1) begin
            n_fail++;
            $display("FAIL wrap_latency: got %0d edges (timeout=%0d), want %0d", 51 + n, to, e.k + 1);
        end
        n_checks++;
        if ({o_found, o_au, o_bu, o_cu} !== {1'b1, 4'd9, 4'd1, 4'd15}) begin
            n_fail++;
            $display("FAIL wrap_result: got found=%b (%0d,%0d,%0d), want found=1 (9,1,15)",
                     o_found, o_au, o_bu, o_cu);
        end
    endtask

    task automatic test_unreachable();
        exp_t e;
        int   n;
        bit   to;
        launch(8'hCE);
        wait_done(n, to);
        e = sb.pop_front();
        n_checks++;
        if (to || n != 4096 || e.k + 1 != 4096) begin
            n_fail++;
            $display("FAIL unreach_latency: got %0d edges (timeout=%0d), want 4096", n, to);
        end
        n_checks++;
        if ({o_found, o_au, o_bu, o_cu} !== {e.found, e.x, e.y, e.z} || e.found !== 1'b0) begin
            n_fail++;
            $display("FAIL unreach_result: got found=%b (%0d,%0d,%0d), want found=0 (0,0,0)",
                     o_found, o_au, o_bu, o_cu);
        end
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL unreach_busy: got %b, want 0", o_busy);
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int   n;
        int   spurious;
        bit   to;
        launch(8'hCE);
        repeat (99) @(posedge i_clk);
        #1;
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_busy_before: got %b, want 1", o_busy);
        end
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        void'(sb.pop_back());
        n_checks++;
        if ({o_busy, o_done, o_found} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_reset: got busy=%b done=%b found=%b, want 0 0 0", o_busy, o_done, o_found);
        end
        i_rst_n = 1'b1;
        spurious = 0;
        repeat (5) begin
            @(posedge i_clk);
            #1;
            if (o_done === 1'b1 || o_busy === 1'b1) spurious++;
        end
        n_checks++;
        if (spurious != 0) begin
            n_fail++;
            $display("FAIL abort_spurious: got %0d active cycles, want 0", spurious);
        end
        launch(8'h06);
        wait_done(n, to);
        e = sb.pop_front();
        n_checks++;
        if (to || n != 2 || n != e.k + 1) begin
            n_fail++;
            $display("FAIL abort_restart_latency: got %0d edges (timeout=%0d), want 2", n, to);
        end
        n_checks++;
        if ({o_found, o_au, o_bu, o_cu} !== {1'b1, 4'd0, 4'd0, 4'd1}) begin
            n_fail++;
            $display("FAIL abort_restart_result: got found=%b (%0d,%0d,%0d), want found=1 (0,0,1)",
                     o_found, o_au, o_bu, o_cu);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n;
        bit   to;
        sb.push_back(model(8'h00));
        sb.push_back(model(8'h00));
        @(negedge i_clk);
        i_start = 1'b1;
        i_fu    = 8'h00;
        for (int r = 0; r < 2; r++) begin
            wait_done(n, to);
            if (r == 1) i_start = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if (to || n != e.k + 2) begin
                n_fail++;
                $display("FAIL b2b_spacing[%0d]: got %0d edges (timeout=%0d), want %0d", r, n, to, e.k + 2);
            end
            n_checks++;
            if ({o_found, o_au, o_bu, o_cu} !== {e.found, e.x, e.y, e.z}) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: got found=%b (%0d,%0d,%0d), want found=%b (%0d,%0d,%0d)",
                         r, o_found, o_au, o_bu, o_cu, e.found, e.x, e.y, e.z);
            end
        end
        @(posedge i_clk);
        #1;
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got busy=%b, want 0", o_busy);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_fu    = 8'h00;
        test_reset();
        test_basic();
        test_wrap_ignore_start();
        test_unreachable();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
